// File: rtl/serdes_pkg.sv
// Shared symbol constants, FSM state type and sizing helper for the SERDES tx path.
package serdes_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;   // comma / idle
   localparam logic [7:0] K27_7 = 8'hFB;   // start of packet
   localparam logic [7:0] K29_7 = 8'hFD;   // end of packet
   localparam logic [7:0] K28_0 = 8'h1C;   // payload underrun filler

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      PAY  = 3'd2,
      EOP  = 3'd3,
      GAP  = 3'd4
   } tx_sched_state_e;

   // Index width for n sources; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serdes_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter
   import serdes_pkg::*;
#(
   parameter  int NUM_SRC = 2,
   localparam int IDX_W   = idx_width(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_SRC-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid
);

   logic [IDX_W:0] cand;

   // Walk candidates ptr, ptr+1, ... modulo NUM_SRC; the first requester wins.
   always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      cand      = '0;
      for (int off = 0; off < NUM_SRC; off++) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(off);
         if (cand >= (IDX_W+1)'(NUM_SRC)) begin
            cand = cand - (IDX_W+1)'(NUM_SRC);
         end
         if (!gnt_valid && req[cand[IDX_W-1:0]]) begin
            gnt_valid                = 1'b1;
            gnt_idx                  = cand[IDX_W-1:0];
            gnt[cand[IDX_W-1:0]]     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/serdes_tx_scheduler.sv
// Symbol-slot transmit scheduler: round-robin packet framing over one serial lane.
//
//   state | meaning
//   IDLE  | emitting commas; may grant a source and emit SOP (K27.7) instead
//   HDR   | emitting the header byte carrying the granted source id
//   PAY   | emitting payload bytes from the granted FIFO (K28.0 when it is empty)
//   EOP   | emitting end of packet (K29.7)
//   GAP   | emitting one mandatory comma before the next grant
module serdes_tx_scheduler
   import serdes_pkg::*;
#(
   parameter  int NUM_SRC          = 2,
   parameter  int BYTES_PER_PACKET = 8,
   parameter  int SYMBOL_CYCLES    = 10,
   localparam int IDX_W            = idx_width(NUM_SRC)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [NUM_SRC-1:0]     src_empty,
   input  logic [NUM_SRC*8-1:0]   src_din,
   output logic [NUM_SRC-1:0]     src_ren,
   output logic [7:0]             sym_data,
   output logic                   sym_k,
   output logic                   slot_start,
   output logic                   busy,
   output logic [IDX_W-1:0]       grant_id,
   output logic                   underrun
);

   localparam int CNT_W = $clog2(SYMBOL_CYCLES);
   localparam int BC_W  = $clog2(BYTES_PER_PACKET + 1);

   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SYMBOL_CYCLES - 1);
   localparam logic [BC_W-1:0]  BYTE_LAST = BC_W'(BYTES_PER_PACKET - 1);

   localparam logic [2:0] S_IDLE = IDLE;
   localparam logic [2:0] S_HDR  = HDR;
   localparam logic [2:0] S_PAY  = PAY;
   localparam logic [2:0] S_EOP  = EOP;
   localparam logic [2:0] S_GAP  = GAP;

   logic [CNT_W-1:0]   slot_cnt_q,   slot_cnt_d;
   logic [2:0]         state_q,      state_d;
   logic [IDX_W-1:0]   rr_ptr_q,     rr_ptr_d;
   logic [IDX_W-1:0]   grant_id_q,   grant_id_d;
   logic [NUM_SRC-1:0] grant_oh_q,   grant_oh_d;
   logic [BC_W-1:0]    byte_cnt_q,   byte_cnt_d;
   logic [7:0]         sym_data_q,   sym_data_d;
   logic               sym_k_q,      sym_k_d;
   logic               slot_start_q, slot_start_d;
   logic [NUM_SRC-1:0] src_ren_q,    src_ren_d;
   logic               busy_q,       busy_d;
   logic               underrun_q,   underrun_d;

   logic               decision;
   logic               granted_empty;
   logic [7:0]         pay_byte;
   logic [NUM_SRC-1:0] arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_valid;

   rr_arbiter #(
      .NUM_SRC (NUM_SRC)
   ) u_arb (
      .req       (~src_empty),
      .ptr       (rr_ptr_q),
      .gnt       (arb_gnt),
      .gnt_idx   (arb_idx),
      .gnt_valid (arb_valid)
   );

   // Decision point, and the granted FIFO's flag/head byte selected by the stored one-hot grant.
   always_comb begin
      decision      = (slot_cnt_q == SLOT_LAST);
      granted_empty = |(src_empty & grant_oh_q);
      pay_byte      = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_oh_q[i]) begin
            pay_byte = pay_byte | src_din[i*8 +: 8];
         end
      end
   end

   // Slot pacing and per-slot packet framing decisions.
   always_comb begin
      slot_cnt_d   = decision ? '0 : slot_cnt_q + CNT_W'(1);
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_id_d   = grant_id_q;
      grant_oh_d   = grant_oh_q;
      byte_cnt_d   = byte_cnt_q;
      sym_data_d   = sym_data_q;
      sym_k_d      = sym_k_q;
      busy_d       = busy_q;
      slot_start_d = 1'b0;
      src_ren_d    = '0;
      underrun_d   = 1'b0;
      if (decision) begin
         slot_start_d = 1'b1;
         case (state_q)
            S_IDLE: begin
               sym_data_d = K28_5;
               sym_k_d    = 1'b1;
               busy_d     = 1'b0;
               if (en && arb_valid) begin
                  // SOP goes out in this very slot, replacing the comma.
                  sym_data_d = K27_7;
                  busy_d     = 1'b1;
                  grant_id_d = arb_idx;
                  grant_oh_d = arb_gnt;
                  rr_ptr_d   = (arb_idx == IDX_W'(NUM_SRC - 1)) ? '0 : arb_idx + IDX_W'(1);
                  state_d    = S_HDR;
               end
            end
            S_HDR: begin
               sym_data_d = 8'(grant_id_q);
               sym_k_d    = 1'b0;
               busy_d     = 1'b1;
               byte_cnt_d = '0;
               state_d    = S_PAY;
            end
            S_PAY: begin
               busy_d = 1'b1;
               if (!granted_empty) begin
                  sym_data_d = pay_byte;
                  sym_k_d    = 1'b0;
                  src_ren_d  = grant_oh_q;
                  byte_cnt_d = byte_cnt_q + BC_W'(1);
                  if (byte_cnt_q == BYTE_LAST) begin
                     state_d = S_EOP;
                  end
               end else begin
                  // Stall the packet with a filler symbol; the byte count does not advance.
                  sym_data_d = K28_0;
                  sym_k_d    = 1'b1;
                  underrun_d = 1'b1;
               end
            end
            S_EOP: begin
               sym_data_d = K29_7;
               sym_k_d    = 1'b1;
               busy_d     = 1'b1;
               state_d    = S_GAP;
            end
            S_GAP: begin
               sym_data_d = K28_5;
               sym_k_d    = 1'b1;
               busy_d     = 1'b0;
               state_d    = S_IDLE;
            end
            default: begin
               sym_data_d = K28_5;
               sym_k_d    = 1'b1;
               busy_d     = 1'b0;
               state_d    = S_IDLE;
            end
         endcase
      end
   end

   // State and output registers; reset drops any partial packet and idles on commas.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt_q   <= '0;
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         grant_id_q   <= '0;
         grant_oh_q   <= '0;
         byte_cnt_q   <= '0;
         sym_data_q   <= K28_5;
         sym_k_q      <= 1'b1;
         slot_start_q <= 1'b0;
         src_ren_q    <= '0;
         busy_q       <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         slot_cnt_q   <= slot_cnt_d;
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_id_q   <= grant_id_d;
         grant_oh_q   <= grant_oh_d;
         byte_cnt_q   <= byte_cnt_d;
         sym_data_q   <= sym_data_d;
         sym_k_q      <= sym_k_d;
         slot_start_q <= slot_start_d;
         src_ren_q    <= src_ren_d;
         busy_q       <= busy_d;
         underrun_q   <= underrun_d;
      end
   end

   assign sym_data   = sym_data_q;
   assign sym_k      = sym_k_q;
   assign slot_start = slot_start_q;
   assign src_ren    = src_ren_q;
   assign busy       = busy_q;
   assign grant_id   = grant_id_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// Scoreboard bench for serdes_tx_scheduler: FIFO models, packet-plan reference model, slot monitor.
module tb_serdes_tx_scheduler;

   localparam int NS  = 2;
   localparam int BPP = 4;
   localparam int SC  = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [NS-1:0] src_empty;
   logic [NS*8-1:0] src_din;
   logic [NS-1:0] src_ren;
   logic [7:0]    sym_data;
   logic          sym_k;
   logic          slot_start;
   logic          busy;
   logic [0:0]    grant_id;
   logic          underrun;

   serdes_tx_scheduler #(
      .NUM_SRC          (NS),
      .BYTES_PER_PACKET (BPP),
      .SYMBOL_CYCLES    (SC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .src_empty  (src_empty),
      .src_din    (src_din),
      .src_ren    (src_ren),
      .sym_data   (sym_data),
      .sym_k      (sym_k),
      .slot_start (slot_start),
      .busy       (busy),
      .grant_id   (grant_id),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   typedef logic [7:0] byte_q_t [$];
   typedef struct {
      logic [7:0]    d;
      logic          k;
      logic [NS-1:0] ren;
      logic          und;
      logic          busy;
      int            gid;
   } exp_t;
   typedef struct {
      bit         pay;
      logic [7:0] sym;
      logic       k;
      logic       busy;
   } plan_t;

   byte_q_t fifo [NS];
   exp_t    exp_q [$];
   plan_t   plan [$];
   int      rr_m = 0;
   int      g_m  = 0;

   int   checks = 0;
   int   errors = 0;
   int   fill_mode = 0;
   logic en_req = 1'b0;
   int   scnt = 0;
   int   mcnt = 0;
   int   ren_cnt [NS];
   int   und_cnt = 0;
   int   busy_slots = 0;
   int   first_fb_gid = -1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic zero_counters();
      for (int i = 0; i < NS; i++) ren_cnt[i] = 0;
      und_cnt      = 0;
      busy_slots   = 0;
      first_fb_gid = -1;
   endtask

   // Reference model: one call per slot. A granted packet becomes a plan of
   // symbols; payload entries stay at the front of the plan until data exists.
   task automatic model_step();
      exp_t  e;
      plan_t p;
      int    g;
      e.ren = '0;
      e.und = 1'b0;
      if (plan.size() == 0) begin
         g = -1;
         if (en) begin
            for (int o = NS - 1; o >= 0; o--) begin
               if (fifo[(rr_m + o) % NS].size() > 0) g = (rr_m + o) % NS;
            end
         end
         if (g < 0) begin
            e.d = 8'hBC; e.k = 1'b1; e.busy = 1'b0;
         end else begin
            g_m  = g;
            rr_m = (g + 1) % NS;
            e.d = 8'hFB; e.k = 1'b1; e.busy = 1'b1;
            plan.push_back('{1'b0, 8'(g), 1'b0, 1'b1});
            repeat (BPP) plan.push_back('{1'b1, 8'h00, 1'b0, 1'b1});
            plan.push_back('{1'b0, 8'hFD, 1'b1, 1'b1});
            plan.push_back('{1'b0, 8'hBC, 1'b1, 1'b0});
         end
      end else begin
         p = plan[0];
         if (!p.pay) begin
            void'(plan.pop_front());
            e.d = p.sym; e.k = p.k; e.busy = p.busy;
         end else if (fifo[g_m].size() > 0) begin
            void'(plan.pop_front());
            e.d = fifo[g_m][0]; e.k = 1'b0; e.busy = 1'b1;
            e.ren[g_m] = 1'b1;
         end else begin
            e.d = 8'h1C; e.k = 1'b1; e.busy = 1'b1; e.und = 1'b1;
         end
      end
      e.gid = g_m;
      exp_q.push_back(e);
   endtask

   // Source FIFOs and DUT inputs change only on falling edges.
   task automatic drive_step();
      if (!rst_n) begin
         scnt = 0;
         plan.delete();
         exp_q.delete();
         rr_m = 0;
         g_m  = 0;
      end else begin
         scnt++;
         for (int i = 0; i < NS; i++) begin
            if (src_ren[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
            if (fill_mode == 1) begin
               while (fifo[i].size() < 2) fifo[i].push_back(8'($urandom));
            end else if (fill_mode == 2) begin
               if (fifo[i].size() < 4 && $urandom_range(0, 99) < 20) fifo[i].push_back(8'($urandom));
            end
         end
      end
      en = en_req;
      for (int i = 0; i < NS; i++) begin
         src_empty[i]      = (fifo[i].size() == 0);
         src_din[i*8 +: 8] = (fifo[i].size() == 0) ? 8'h00 : fifo[i][0];
      end
      if (rst_n && (scnt % SC) == SC - 1) model_step();
   endtask

   initial begin
      en        = 1'b0;
      src_empty = '1;
      src_din   = '0;
      forever begin
         @(negedge clk);
         drive_step();
      end
   end

   // Monitor: slot_start cadence, per-slot scoreboard compare, no stray strobes.
   initial begin
      exp_t e;
      logic want_slot;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mcnt = 0;
         end else begin
            mcnt++;
            want_slot = ((mcnt % SC) == 0);
            checks++;
            if (slot_start !== want_slot) begin
               errors++;
               $display("FAIL slot_start_timing cycle %0d: got %b want %b", mcnt, slot_start, want_slot);
            end
            if (slot_start === 1'b1) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL slot_no_expectation cycle %0d: got sym %h k %b, want none", mcnt, sym_data, sym_k);
               end else begin
                  e = exp_q.pop_front();
                  if ({sym_data, sym_k, src_ren, underrun, busy, grant_id} !==
                      {e.d, e.k, e.ren, e.und, e.busy, 1'(e.gid)}) begin
                     errors++;
                     $display("FAIL slot cycle %0d: got d=%h k=%b ren=%b und=%b busy=%b gid=%0d want d=%h k=%b ren=%b und=%b busy=%b gid=%0d",
                              mcnt, sym_data, sym_k, src_ren, underrun, busy, grant_id,
                              e.d, e.k, e.ren, e.und, e.busy, e.gid);
                  end
               end
               for (int i = 0; i < NS; i++) if (src_ren[i]) ren_cnt[i]++;
               if (underrun) und_cnt++;
               if (busy) busy_slots++;
               if (sym_data == 8'hFB && sym_k && first_fb_gid < 0) first_fb_gid = int'(grant_id);
            end else begin
               checks++;
               if (src_ren !== '0 || underrun !== 1'b0) begin
                  errors++;
                  $display("FAIL strobe_outside_slot cycle %0d: got ren=%b und=%b want 0", mcnt, src_ren, underrun);
               end
            end
         end
      end
   end

   initial begin
      int t;
      rst_n = 1'b0;
      zero_counters();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      // Idle with empty sources: commas only.
      en_req = 1'b1;
      run(100);
      chk("idle_no_pop", 32'(ren_cnt[0] + ren_cnt[1]), 32'd0);
      chk("idle_not_busy", 32'(busy_slots), 32'd0);

      // Single packet from source 0.
      zero_counters();
      fifo[0].push_back(8'h11); fifo[0].push_back(8'h22);
      fifo[0].push_back(8'h33); fifo[0].push_back(8'h44);
      run(120);
      chk("pkt_pops_src0", 32'(ren_cnt[0]), 32'd4);
      chk("pkt_pops_src1", 32'(ren_cnt[1]), 32'd0);
      chk("pkt_busy_slots", 32'(busy_slots), 32'd7);

      // Both sources always non-empty: alternating grants.
      zero_counters();
      fill_mode = 1;
      run(400);
      chk("rr_fairness", 32'((ren_cnt[0] > ren_cnt[1] ? ren_cnt[0] - ren_cnt[1] : ren_cnt[1] - ren_cnt[0]) <= BPP), 32'd1);

      // Underrun: source 1 runs dry for three slots mid-packet.
      en_req = 1'b0;
      fill_mode = 0;
      run(150);
      chk("drain_idle", 32'(busy), 32'd0);
      fifo[0].delete();
      fifo[1].delete();
      fifo[1].push_back(8'hA1); fifo[1].push_back(8'hA2);
      zero_counters();
      en_req = 1'b1;
      t = 0;
      while (und_cnt < 3 && t < 400) begin run(1); t++; end
      chk("underrun_wait_timeout", 32'(t < 400), 32'd1);
      fifo[1].push_back(8'hA3); fifo[1].push_back(8'hA4);
      run(150);
      chk("underrun_count", 32'(und_cnt), 32'd3);
      chk("underrun_pops_src1", 32'(ren_cnt[1]), 32'd4);
      chk("underrun_busy_slots", 32'(busy_slots), 32'd10);

      // Drop en mid-packet: packet completes, then idle until en returns.
      fill_mode = 1;
      t = 0;
      while (busy !== 1'b1 && t < 300) begin run(1); t++; end
      chk("busy_wait_timeout", 32'(t < 300), 32'd1);
      run(35);
      en_req = 1'b0;
      run(100);
      zero_counters();
      run(200);
      chk("en_low_no_busy", 32'(busy_slots), 32'd0);
      chk("en_low_no_pop", 32'(ren_cnt[0] + ren_cnt[1]), 32'd0);
      zero_counters();
      en_req = 1'b1;
      run(20);
      chk("en_return_grant", 32'(busy_slots >= 1), 32'd1);

      // Asynchronous reset in the middle of a payload.
      t = 0;
      while (busy !== 1'b0 && t < 300) begin run(1); t++; end
      while (busy !== 1'b1 && t < 600) begin run(1); t++; end
      chk("pay_wait_timeout", 32'(t < 600), 32'd1);
      run(25);
      en_req = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_sym_data", 32'(sym_data), 32'hBC);
      chk("rst_sym_k", 32'(sym_k), 32'd1);
      chk("rst_src_ren", 32'(src_ren), 32'd0);
      chk("rst_slot_start", 32'(slot_start), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      run(60);
      zero_counters();
      en_req = 1'b1;
      run(100);
      chk("post_rst_first_grant", 32'(first_fb_gid), 32'd0);

      // Randomised traffic with sparse refills and toggling enable.
      fill_mode = 2;
      repeat (30) begin
         en_req = ($urandom_range(0, 99) < 80);
         run($urandom_range(20, 80));
      end
      chk("scoreboard_drained", 32'(exp_q.size() <= 1), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
